// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths, constants and FSM encoding for the fetch stage (option macro: IF_MISALIGN_CHK_EN)
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef IF_BUF_DEPTH
`define IF_BUF_DEPTH 2
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package inst_fetch_pkg;
  localparam int XLEN             = `CPU_WIDTH;
  localparam int IF_BUF_DEPTH_DEF = `IF_BUF_DEPTH;
  localparam logic [XLEN-1:0] NOP_WORD = `INST_NOP;

  // Fetch FSM encoding
  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  // One buffered instruction: word plus the PC it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_buf.sv
// rtl/inst_fetch_buf.sv - synchronous FIFO with push/pop/flush and full/empty/count
module inst_fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o;

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  // Pointer and occupancy update; flush discards every entry regardless of push/pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I fetch stage: PC, imem req/gnt/rvalid, instruction buffer, redirects (option macro: IF_MISALIGN_CHK_EN)
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = IF_BUF_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            fetch_misalign
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] tgt_pc;
  logic            tgt_bad;
  logic [CW-1:0]   in_flight;
  logic [CW:0]     credit_used;
  logic            fire, push, pop, rsp_drop;

  logic [2*XLEN-1:0] buf_head;
  fetch_entry_t      head_entry;
  logic              buf_full, buf_empty;
  logic [CW-1:0]     buf_count;

  logic [XLEN-1:0] rsp_pc;
  logic            pcq_full, pcq_empty;
  logic [CW-1:0]   pcq_count;

`ifdef IF_MISALIGN_CHK_EN
  assign tgt_pc         = redirect_pc;
  assign tgt_bad        = (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
`else
  assign tgt_pc  = redirect_pc & ~XLEN'(3);
  assign tgt_bad = 1'b0;
`endif

  // Responses still owed by memory after this cycle's rvalid
  assign in_flight = outst_q - CW'(imem_rvalid);
  // A response is stale if older redirects marked it or a redirect arrives with it
  assign rsp_drop  = imem_rvalid && ((drop_q != '0) || redirect_valid);
  assign push      = imem_rvalid && !rsp_drop;
  assign pop       = inst_valid && inst_ready;
  assign fire      = imem_req && imem_gnt;

  // A pop this cycle frees a slot for the request issued now, keeping one inst/cycle
  assign credit_used = {1'b0, buf_count} - (CW+1)'(pop) + {1'b0, outst_q};
  assign imem_req    = (state_q == ST_RUN) && !redirect_valid && !misalign_q &&
                       (credit_used < (CW+1)'(BUF_DEPTH));
  assign imem_addr   = pc_q;

  assign head_entry = fetch_entry_t'(buf_head);
  assign inst_valid = !buf_empty;
  assign inst       = inst_valid ? head_entry.inst : NOP_WORD;
  assign inst_pc    = inst_valid ? head_entry.pc : '0;

  // Next-state: PC, outstanding/drop counters, misalign flag and FSM
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    outst_d    = outst_q + CW'(fire) - CW'(imem_rvalid);
    drop_d     = drop_q;
    misalign_d = misalign_q;
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    if (redirect_valid) begin
      // Every response still owed now belongs to the old path, including ones already marked
      pc_d       = tgt_pc;
      drop_d     = in_flight;
      misalign_d = tgt_bad;
    end else if (fire) begin
      pc_d = pc_q + XLEN'(4);
    end
    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN,
      ST_FLUSH: state_d = (drop_d != '0) ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Fetch control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      misalign_q <= misalign_d;
    end
  end

  inst_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (2*XLEN),
    .CW    (CW)
  ) u_inst_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({imem_rdata, rsp_pc}),
    .pop_i       (pop),
    .head_o      (buf_head),
    .full_o      (buf_full),
    .empty_o     (buf_empty),
    .count_o     (buf_count)
  );

  // PC shadow of granted requests; every response (kept or dropped) retires one entry
  inst_fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (XLEN),
    .CW    (CW)
  ) u_pc_q (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (1'b0),
    .push_i      (fire),
    .push_data_i (pc_q),
    .pop_i       (imem_rvalid),
    .head_o      (rsp_pc),
    .full_o      (pcq_full),
    .empty_o     (pcq_empty),
    .count_o     (pcq_count)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && buf_full));
  a_pc_shadow:    assert property (@(posedge clk) disable iff (!rst_n) pcq_count == outst_q);
  a_rsp_known:    assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid && pcq_empty));
  a_req_room:     assert property (@(posedge clk) disable iff (!rst_n) !(fire && pcq_full));
endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
`ifdef IF_MISALIGN_CHK_EN
  logic        fetch_misalign;
`endif

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic        rsp_hold;
  logic [31:0] pend[$];
  logic [31:0] pops[$];

  inst_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // One clock: sample handshakes mid-cycle, then update the memory model after the edge.
  // Memory returns each granted word one cycle after gnt with rdata = ~addr.
  task automatic tick();
    logic        acc, popv;
    logic [31:0] acc_addr, pop_pc, a;
    @(negedge clk);
    acc      = imem_req && imem_gnt;
    acc_addr = imem_addr;
    popv     = inst_valid && inst_ready;
    pop_pc   = inst_pc;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      if (popv) pops.push_back(pop_pc);
      if (acc)  pend.push_back(acc_addr);
      if (!rsp_hold && pend.size() > 0) begin
        a = pend.pop_front();
        imem_rvalid = 1'b1;
        imem_rdata  = ~a;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    inst_ready = 1'b0; rsp_hold = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend.delete(); pops.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    inst_ready = 1'b0; rsp_hold = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    pend.delete(); pops.delete();
    repeat (2) @(posedge clk);
    #2;
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req: got %0h want 0", imem_req); end
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    vec_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %0h want 0", inst_valid); end
    vec_cnt++; if (inst !== 32'h0000_0013) begin err_cnt++; $display("FAIL reset_inst: got %h want 00000013", inst); end
    vec_cnt++; if (inst_pc !== 32'h0) begin err_cnt++; $display("FAIL reset_pc: got %h want 00000000", inst_pc); end
    rst_n = 1'b1; imem_gnt = 1'b1; inst_ready = 1'b1;
    #1;
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL boot_req: got %0h want 0", imem_req); end
    tick();
    vec_cnt++; if (imem_req !== 1'b1) begin err_cnt++; $display("FAIL run_req: got %0h want 1", imem_req); end
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL midreset_valid: got %0h want 0", inst_valid); end
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL midreset_req: got %0h want 0", imem_req); end
    vec_cnt++; if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL midreset_addr: got %h want 00000000", imem_addr); end
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    tick();
    vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL stream_first: got req=%0h addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
    tick();
    vec_cnt++; if (inst_valid !== 1'b0 || inst !== 32'h13) begin err_cnt++; $display("FAIL stream_nobypass: got valid=%0h inst=%h want valid=0 inst=00000013", inst_valid, inst); end
    vec_cnt++; if (imem_addr !== 32'h4) begin err_cnt++; $display("FAIL stream_addr2: got %h want 00000004", imem_addr); end
    for (int k = 3; k <= 11; k++) begin
      if (k > 3) tick();
      else tick();
      exp_pc = 32'(4 * (k - 3));
      vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== ~exp_pc) begin err_cnt++; $display("FAIL stream_inst[%0d]: got v=%0h pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, exp_pc, ~exp_pc); end
      vec_cnt++; if (imem_addr !== 32'(4 * (k - 1))) begin err_cnt++; $display("FAIL stream_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * (k - 1))); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    repeat (4) tick();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL bp_req[%0d]: got %0h want 0", i, imem_req); end
      vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== ~32'h4) begin err_cnt++; $display("FAIL bp_hold[%0d]: got v=%0h pc=%h inst=%h want v=1 pc=00000004 inst=fffffffb", i, inst_valid, inst_pc, inst); end
    end
    inst_ready = 1'b1;
    exp_pc = 32'h8;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc) begin err_cnt++; $display("FAIL bp_resume[%0d]: got v=%0h pc=%h want v=1 pc=%h", i, inst_valid, inst_pc, exp_pc); end
      exp_pc = exp_pc + 32'h4;
    end
    vec_cnt++; if (pops.size() !== 4) begin err_cnt++; $display("FAIL bp_popcount: got %0d want 4", pops.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vec_cnt++; if (pops[i] !== 32'(4 * i)) begin err_cnt++; $display("FAIL bp_poporder[%0d]: got %h want %h", i, pops[i], 32'(4 * i)); end
      end
    end
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    imem_gnt = 1'b0; inst_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin err_cnt++; $display("FAIL gnt_stall[%0d]: got req=%0h addr=%h want req=1 addr=00000000", i, imem_req, imem_addr); end
    end
    imem_gnt = 1'b1;
    tick();
    vec_cnt++; if (imem_addr !== 32'h4) begin err_cnt++; $display("FAIL gnt_advance: got %h want 00000004", imem_addr); end
    imem_gnt = 1'b0;
    tick();
    vec_cnt++; if (imem_addr !== 32'h4 || imem_req !== 1'b1) begin err_cnt++; $display("FAIL gnt_single: got req=%0h addr=%h want req=1 addr=00000004", imem_req, imem_addr); end
    vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin err_cnt++; $display("FAIL gnt_inst: got v=%0h pc=%h want v=1 pc=00000000", inst_valid, inst_pc); end
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1; rsp_hold = 1'b1;
    repeat (3) tick();
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rf_credit: got req=%0h want 0", imem_req); end
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    vec_cnt++; if (imem_req !== 1'b0) begin err_cnt++; $display("FAIL rf_noreq_redirect: got %0h want 0", imem_req); end
    tick();
    redirect_valid = 1'b0;
    #1;
    vec_cnt++; if (dut.state_q !== ST_FLUSH || dut.drop_q !== 2'd2) begin err_cnt++; $display("FAIL rf_flush: got state=%0d drop=%0d want state=2 drop=2", dut.state_q, dut.drop_q); end
    vec_cnt++; if (imem_addr !== 32'h100 || imem_req !== 1'b0) begin err_cnt++; $display("FAIL rf_pc: got req=%0h addr=%h want req=0 addr=00000100", imem_req, imem_addr); end
    rsp_hold = 1'b0;
    tick();
    tick();
    vec_cnt++; if (dut.state_q !== ST_FLUSH || dut.drop_q !== 2'd1 || inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rf_drop1: got state=%0d drop=%0d v=%0h want state=2 drop=1 v=0", dut.state_q, dut.drop_q, inst_valid); end
    tick();
    vec_cnt++; if (dut.state_q !== ST_RUN || imem_req !== 1'b1 || imem_addr !== 32'h100) begin err_cnt++; $display("FAIL rf_resume: got state=%0d req=%0h addr=%h want state=1 req=1 addr=00000100", dut.state_q, imem_req, imem_addr); end
    vec_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rf_nostale: got v=%0h want 0", inst_valid); end
    repeat (2) tick();
    vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== ~32'h100) begin err_cnt++; $display("FAIL rf_newinst: got v=%0h pc=%h inst=%h want v=1 pc=00000100 inst=fffffeff", inst_valid, inst_pc, inst); end
    vec_cnt++; if (pops.size() !== 0) begin err_cnt++; $display("FAIL rf_pops: got %0d want 0", pops.size()); end
  endtask

  task automatic test_redirect_pop_rvalid();
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    repeat (4) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    #1;
    vec_cnt++; if (pops.size() !== 2 || pops[pops.size()-1] !== 32'h4) begin err_cnt++; $display("FAIL rp_popped: got n=%0d last=%h want n=2 last=00000004", pops.size(), pops[pops.size()-1]); end
    vec_cnt++; if (inst_valid !== 1'b0) begin err_cnt++; $display("FAIL rp_flushed: got v=%0h want 0", inst_valid); end
    vec_cnt++; if (dut.drop_q !== 2'd0 || dut.state_q !== ST_RUN) begin err_cnt++; $display("FAIL rp_drop: got drop=%0d state=%0d want drop=0 state=1", dut.drop_q, dut.state_q); end
    vec_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin err_cnt++; $display("FAIL rp_req: got req=%0h addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
    repeat (2) tick();
    vec_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40 || inst !== ~32'h40) begin err_cnt++; $display("FAIL rp_newinst: got v=%0h pc=%h inst=%h want v=1 pc=00000040 inst=ffffffbf", inst_valid, inst_pc, inst); end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign();
    apply_reset();
    imem_gnt = 1'b1; inst_ready = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++; if (fetch_misalign !== 1'b1 || imem_req !== 1'b0) begin err_cnt++; $display("FAIL ma_set[%0d]: got mis=%0h req=%0h want mis=1 req=0", i, fetch_misalign, imem_req); end
    end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    #1;
    vec_cnt++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin err_cnt++; $display("FAIL ma_clear: got mis=%0h req=%0h addr=%h want mis=0 req=1 addr=00000200", fetch_misalign, imem_req, imem_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect_flush();
    test_redirect_pop_rvalid();
`ifdef IF_MISALIGN_CHK_EN
    test_misalign();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
